// File: rtl/game_tick_scheduler.sv
// Game timing scheduler: turns the board clock into single-cycle ball/paddle enable strobes
// and sequences the game through idle, serve delay, run and pause.
module game_tick_scheduler #(
   parameter int PRESCALE      = 1000,
   parameter int BALL_PER_MAX  = 320,
   parameter int BALL_PER_MIN  = 80,
   parameter int SPEED_STEP    = 20,
   parameter int HITS_PER_STEP = 4,
   parameter int PADDLE_PER    = 200,
   parameter int SERVE_TICKS   = 50000
) (
   input  logic       clk_i,
   input  logic       btnC_i,
   input  logic       start_i,
   input  logic       pause_tgl_i,
   input  logic       hit_i,
   input  logic       miss_i,
   output logic       ball_tick_o,
   output logic       paddle_tick_o,
   output logic       serving_o,
   output logic       running_o,
   output logic [3:0] speed_lvl_o
);

   localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BC_W  = (BALL_PER_MAX > 1) ? $clog2(BALL_PER_MAX) : 1;
   localparam int PER_W = $clog2(BALL_PER_MAX + 1);
   localparam int PD_W  = (PADDLE_PER > 1) ? $clog2(PADDLE_PER) : 1;
   localparam int SV_W  = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
   localparam int HT_W  = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;

   localparam logic [PER_W-1:0] PER_MAX  = PER_W'(BALL_PER_MAX);
   localparam logic [PER_W-1:0] PER_MIN  = PER_W'(BALL_PER_MIN);
   localparam logic [PER_W-1:0] PER_STEP = PER_W'(SPEED_STEP);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SERVE = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_PAUSE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [PS_W-1:0]  presc_q, presc_d;
   logic [SV_W-1:0]  serveCnt_q, serveCnt_d;
   logic [BC_W-1:0]  ballCnt_q, ballCnt_d;
   logic [PD_W-1:0]  paddleCnt_q, paddleCnt_d;
   logic [PER_W-1:0] period_q, period_d;
   logic [HT_W-1:0]  hitCnt_q, hitCnt_d;
   logic [3:0]       speedLvl_q, speedLvl_d;
   logic             ballTick_q, ballTick_d;
   logic             paddleTick_q, paddleTick_d;
   logic             serving_q, running_q;
   logic             baseTick;

   assign baseTick = (presc_q == PS_W'(PRESCALE - 1));

   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      serveCnt_d   = serveCnt_q;
      ballCnt_d    = ballCnt_q;
      paddleCnt_d  = paddleCnt_q;
      period_d     = period_q;
      hitCnt_d     = hitCnt_q;
      speedLvl_d   = speedLvl_q;
      ballTick_d   = 1'b0;
      paddleTick_d = 1'b0;

      if (state_q != S_IDLE)
         presc_d = baseTick ? '0 : presc_q + 1'b1;

      if ((state_q == S_SERVE || state_q == S_RUN) && baseTick) begin
         if (paddleCnt_q == PD_W'(PADDLE_PER - 1)) begin
            paddleCnt_d  = '0;
            paddleTick_d = 1'b1;
         end else begin
            paddleCnt_d = paddleCnt_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            presc_d     = '0;
            serveCnt_d  = '0;
            ballCnt_d   = '0;
            paddleCnt_d = '0;
            period_d    = PER_MAX;
            hitCnt_d    = '0;
            speedLvl_d  = '0;
            if (start_i)
               state_d = S_SERVE;
         end
         S_SERVE: begin
            if (baseTick) begin
               if (serveCnt_q == SV_W'(SERVE_TICKS - 1)) begin
                  serveCnt_d = '0;
                  ballCnt_d  = '0;
                  state_d    = S_RUN;
               end else begin
                  serveCnt_d = serveCnt_q + 1'b1;
               end
            end
         end
         S_RUN: begin
            // Compare uses the period in force before any hit this cycle; a shrunken period catches up on the next base tick.
            if (baseTick) begin
               if (PER_W'(ballCnt_q) >= period_q - 1'b1) begin
                  ballCnt_d  = '0;
                  ballTick_d = 1'b1;
               end else begin
                  ballCnt_d = ballCnt_q + 1'b1;
               end
            end
            if (miss_i) begin
               state_d    = S_SERVE;
               serveCnt_d = '0;
               period_d   = PER_MAX;
               hitCnt_d   = '0;
               speedLvl_d = '0;
            end else begin
               if (hit_i) begin
                  if (hitCnt_q == HT_W'(HITS_PER_STEP - 1)) begin
                     hitCnt_d = '0;
                     if (period_q > PER_MIN) begin
                        if (int'(period_q) >= BALL_PER_MIN + SPEED_STEP)
                           period_d = period_q - PER_STEP;
                        else
                           period_d = PER_MIN;
                        if (speedLvl_q != 4'd15)
                           speedLvl_d = speedLvl_q + 4'd1;
                     end
                  end else begin
                     hitCnt_d = hitCnt_q + 1'b1;
                  end
               end
               if (pause_tgl_i)
                  state_d = S_PAUSE;
            end
         end
         default: begin
            if (pause_tgl_i)
               state_d = S_RUN;
         end
      endcase
   end

   // Status outputs decode the next state so they line up with the state register itself.
   always_ff @(posedge clk_i or negedge btnC_i) begin
      if (!btnC_i) begin
         state_q      <= S_IDLE;
         presc_q      <= '0;
         serveCnt_q   <= '0;
         ballCnt_q    <= '0;
         paddleCnt_q  <= '0;
         period_q     <= PER_MAX;
         hitCnt_q     <= '0;
         speedLvl_q   <= '0;
         ballTick_q   <= 1'b0;
         paddleTick_q <= 1'b0;
         serving_q    <= 1'b0;
         running_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         serveCnt_q   <= serveCnt_d;
         ballCnt_q    <= ballCnt_d;
         paddleCnt_q  <= paddleCnt_d;
         period_q     <= period_d;
         hitCnt_q     <= hitCnt_d;
         speedLvl_q   <= speedLvl_d;
         ballTick_q   <= ballTick_d;
         paddleTick_q <= paddleTick_d;
         serving_q    <= (state_d == S_SERVE);
         running_q    <= (state_d == S_RUN);
      end
   end

   assign ball_tick_o   = ballTick_q;
   assign paddle_tick_o = paddleTick_q;
   assign serving_o     = serving_q;
   assign running_o     = running_q;
   assign speed_lvl_o   = speedLvl_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Self-checking bench for game_tick_scheduler: directed game sequence plus random pulses,
// compared every cycle against an integer-arithmetic model of the game rules.
module tb_game_tick_scheduler;

   localparam int PRESCALE      = 4;
   localparam int BALL_PER_MAX  = 10;
   localparam int BALL_PER_MIN  = 4;
   localparam int SPEED_STEP    = 3;
   localparam int HITS_PER_STEP = 2;
   localparam int PADDLE_PER    = 5;
   localparam int SERVE_TICKS   = 6;

   localparam int M_IDLE  = 0;
   localparam int M_SERVE = 1;
   localparam int M_RUN   = 2;
   localparam int M_PAUSE = 3;

   logic       clk = 1'b0;
   logic       btnC = 1'b0;
   logic       startIn = 1'b0;
   logic       pauseIn = 1'b0;
   logic       hitIn = 1'b0;
   logic       missIn = 1'b0;
   logic       ballTick, paddleTick, serving, running;
   logic [3:0] speedLvl;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int mMode, mT, mServe, mBall, mPaddle, mPer, mHits, mLvl;
   bit eBall, ePaddle, eServing, eRunning;

   game_tick_scheduler #(
      .PRESCALE(PRESCALE), .BALL_PER_MAX(BALL_PER_MAX), .BALL_PER_MIN(BALL_PER_MIN),
      .SPEED_STEP(SPEED_STEP), .HITS_PER_STEP(HITS_PER_STEP), .PADDLE_PER(PADDLE_PER),
      .SERVE_TICKS(SERVE_TICKS)
   ) dut (
      .clk_i(clk), .btnC_i(btnC), .start_i(startIn), .pause_tgl_i(pauseIn),
      .hit_i(hitIn), .miss_i(missIn), .ball_tick_o(ballTick), .paddle_tick_o(paddleTick),
      .serving_o(serving), .running_o(running), .speed_lvl_o(speedLvl)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mMode = M_IDLE; mT = 0; mServe = 0; mBall = 0; mPaddle = 0;
      mPer = BALL_PER_MAX; mHits = 0; mLvl = 0;
      eBall = 0; ePaddle = 0; eServing = 0; eRunning = 0;
   endtask

   // Game rules in plain integers: ticks elapsed are counted up until they reach the period.
   task automatic modelStep(input bit st, input bit pt, input bit h, input bit mi);
      int  mode;
      bit  bt;
      int  newPer;
      mode = mMode;
      bt = (mode != M_IDLE) && (mT % PRESCALE == PRESCALE - 1);
      eBall = 0;
      ePaddle = 0;
      if (mode == M_IDLE) begin
         mT = 0; mServe = 0; mBall = 0; mPaddle = 0;
         if (st) mMode = M_SERVE;
      end else begin
         mT++;
         if (bt && (mode == M_SERVE || mode == M_RUN)) begin
            mPaddle++;
            if (mPaddle == PADDLE_PER) begin mPaddle = 0; ePaddle = 1; end
         end
         if (mode == M_SERVE && bt) begin
            mServe++;
            if (mServe == SERVE_TICKS) begin mServe = 0; mBall = 0; mMode = M_RUN; end
         end
         if (mode == M_RUN) begin
            if (bt) begin
               mBall++;
               if (mBall >= mPer) begin mBall = 0; eBall = 1; end
            end
            if (mi) begin
               mMode = M_SERVE; mServe = 0; mPer = BALL_PER_MAX; mHits = 0; mLvl = 0;
            end else begin
               if (h) begin
                  mHits++;
                  if (mHits == HITS_PER_STEP) begin
                     mHits = 0;
                     newPer = (mPer - SPEED_STEP > BALL_PER_MIN) ? mPer - SPEED_STEP : BALL_PER_MIN;
                     if (newPer != mPer) mLvl = (mLvl < 15) ? mLvl + 1 : 15;
                     mPer = newPer;
                  end
               end
               if (pt) mMode = M_PAUSE;
            end
         end
         if (mode == M_PAUSE && pt) mMode = M_RUN;
      end
      eServing = (mMode == M_SERVE);
      eRunning = (mMode == M_RUN);
   endtask

   task automatic checkOutput();
      check("ball_tick", ballTick, eBall);
      check("paddle_tick", paddleTick, ePaddle);
      check("serving", serving, eServing);
      check("running", running, eRunning);
      check("speed_lvl", speedLvl, mLvl);
   endtask

   task automatic applyStimulus(input bit st, input bit pt, input bit h, input bit mi);
      @(negedge clk);
      startIn = st; pauseIn = pt; hitIn = h; missIn = mi;
      @(posedge clk);
      modelStep(st, pt, h, mi);
      cyc++;
      #1;
      checkOutput();
   endtask

   task automatic waitFor(input int sel, input int bound, output int at, output bit ok);
      ok = 0;
      at = 0;
      for (int i = 0; i < bound && !ok; i++) begin
         applyStimulus(0, 0, 0, 0);
         if ((sel == 0 && ballTick) || (sel == 1 && paddleTick) || (sel == 2 && running)) begin
            ok = 1;
            at = cyc;
         end
      end
   endtask

   task automatic measureGap(input int exp, input string tag);
      int t1, t2;
      bit ok1, ok2;
      waitFor(0, 200, t1, ok1);
      check({tag, "_first_seen"}, ok1, 1);
      waitFor(0, 200, t2, ok2);
      check({tag, "_second_seen"}, ok2, 1);
      check(tag, t2 - t1, exp);
   endtask

   task automatic hitsInRun(input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(1, 12)) applyStimulus(0, 0, 0, 0);
         applyStimulus(0, 0, 1, 0);
      end
   endtask

   initial begin
      int  entry, at, strobes;
      bit  ok;
      int  r;

      modelReset();
      #1;
      check("reset_ball", ballTick, 0);
      check("reset_paddle", paddleTick, 0);
      check("reset_serving", serving, 0);
      check("reset_running", running, 0);
      check("reset_lvl", speedLvl, 0);
      repeat (3) @(negedge clk);
      btnC = 1'b1;
      repeat (5) applyStimulus(0, 1, 1, 1);

      $display("[TB] serve sequence");
      applyStimulus(1, 0, 0, 0);
      entry = cyc;
      check("serving_after_start", serving, 1);
      waitFor(1, 40, at, ok);
      check("first_paddle_seen", ok, 1);
      check("first_paddle_delay", at - entry, 20);
      waitFor(2, 40, at, ok);
      check("run_seen", ok, 1);
      check("serve_to_run", at - entry, 24);

      $display("[TB] ball period and speed ramp");
      measureGap(40, "gap_lvl0");
      hitsInRun(2);
      measureGap(28, "gap_lvl1");
      check("lvl1", speedLvl, 1);
      hitsInRun(2);
      measureGap(16, "gap_lvl2");
      check("lvl2", speedLvl, 2);
      hitsInRun(2);
      measureGap(16, "gap_floor");
      check("lvl_floor", speedLvl, 2);

      $display("[TB] pause and resume");
      repeat ($urandom_range(3, 30)) applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0);
      check("paused_not_running", running, 0);
      strobes = 0;
      for (int i = 0; i < 200; i++) begin
         applyStimulus(0, 0, $urandom_range(0, 1), 0);
         if (ballTick || paddleTick) strobes++;
      end
      check("strobes_in_pause", strobes, 0);
      applyStimulus(0, 1, 0, 0);
      check("resumed_running", running, 1);
      repeat (60) applyStimulus(0, 0, 0, 0);

      $display("[TB] hit and miss together");
      applyStimulus(0, 0, 1, 1);
      check("miss_serving", serving, 1);
      check("miss_lvl", speedLvl, 0);
      waitFor(2, 40, at, ok);
      check("rerun_seen", ok, 1);
      measureGap(40, "gap_after_miss");

      $display("[TB] asynchronous reset mid-run");
      repeat ($urandom_range(1, 20)) applyStimulus(0, 0, 0, 0);
      #2 btnC = 1'b0;
      #1;
      check("async_ball", ballTick, 0);
      check("async_paddle", paddleTick, 0);
      check("async_serving", serving, 0);
      check("async_running", running, 0);
      check("async_lvl", speedLvl, 0);
      modelReset();
      @(negedge clk);
      btnC = 1'b1;
      repeat (30) applyStimulus(0, 1, 1, 0);
      check("idle_after_reset", serving, 0);
      applyStimulus(1, 0, 0, 0);
      check("restart_serving", serving, 1);

      $display("[TB] random pulses");
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 199);
         applyStimulus(r == 7, r >= 190 && r < 193, r < 18 || r == 191, r == 100);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
